// File: rtl/rf_stream_pkg.sv
// Shared constants, FSM state type and power-on row image for the row
// register file and the one-hot row encoder that consumes it.
package rf_stream_pkg;

  localparam int unsigned RF_DEPTH = 8;
  localparam int unsigned RF_WIDTH = 16;
  localparam int unsigned RF_IDX_W = $clog2(RF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PRESENT,
    DONE
  } state_e;

  // Image restored into the register file on every reset.
  localparam logic [RF_WIDTH-1:0] DEFAULT_IMAGE [RF_DEPTH] = '{
    16'h0000, 16'h8800, 16'h0100, 16'h8000,
    16'h0001, 16'h0800, 16'h8110, 16'h0080
  };

  // Default contents of row i; rows beyond the stored image read as zero.
  function automatic logic [RF_WIDTH-1:0] default_row(input int unsigned i);
    logic [RF_WIDTH-1:0] r;
    r = '0;
    if (i < RF_DEPTH) begin
      r = DEFAULT_IMAGE[i[RF_IDX_W-1:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// Two-flop synchronizer for a raw push-button pin followed by a registered
// rising-edge detector; rise_o is a single-cycle pulse three clocks after
// the pin goes high.
module pb_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pb_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic rise_q;

  // Synchronize the pin, keep its previous value and register the edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= pb_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/rf_row_streamer.sv
// Row register file with a write port and a paced, flow-controlled reader
// that presents rows 0..DEPTH-1 over valid/ready after a push-button start.
module rf_row_streamer
  import rf_stream_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned PACE  = 100_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start_pb,
  output logic [WIDTH-1:0]         row_data,
  output logic [$clog2(DEPTH)-1:0] row_idx,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic                     last,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_drop
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(PACE - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DEPTH - 1);

  logic              start_rise;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_accept;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  row_data_q, row_data_d;
  logic [IW-1:0]     row_idx_q, row_idx_d;
  logic              row_valid_q, row_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  pb_sync_edge u_start_sync (
    .clk    (clk),
    .rst    (rst),
    .pb_i   (start_pb),
    .rise_o (start_rise)
  );

  // Writes land only while no run is in flight.
  assign wr_accept = wr_en && ((state_q == IDLE) || (state_q == DONE));

  // Register file: default image on reset, otherwise accepted writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(default_row(i));
      end
    end else if (wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // FSM state, run pointer, pacing counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: pace each row, hold it until accepted, stop after the last.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    row_valid_d = row_valid_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = WAIT;
          ptr_d   = '0;
          cnt_d   = CNT_RELOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = PRESENT;
          row_data_d  = mem_q[ptr_q];
          row_idx_d   = ptr_q;
          row_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PRESENT: begin
        if (row_valid_q && row_ready) begin
          row_valid_d = 1'b0;
          if (ptr_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            ptr_d   = ptr_q + IW'(1);
            cnt_d   = CNT_RELOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they register alongside it.
    busy_d = (state_d == WAIT) || (state_d == PRESENT);
    done_d = (state_d == DONE);
  end

  assign row_data  = row_data_q;
  assign row_idx   = row_idx_q;
  assign row_valid = row_valid_q;
  assign last      = row_valid_q && (row_idx_q == LAST_IDX);
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_drop   = wr_en && busy_q && !rst;

endmodule

// File: tb/tb_rf_row_streamer.sv
// Scoreboard bench for rf_row_streamer: the stimulus process predicts each
// run's rows from a reference image and queues them; a negedge monitor pops
// and compares on every accepted transfer and checks pacing and stalls.
module tb_rf_row_streamer;

  localparam int unsigned PACE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start_pb;
  logic [15:0] row_data;
  logic [2:0]  row_idx;
  logic        row_valid;
  logic        row_ready;
  logic        last;
  logic        busy;
  logic        done;
  logic        wr_drop;

  always #5 clk = ~clk;

  rf_row_streamer #(.DEPTH(8), .WIDTH(16), .PACE(PACE)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start_pb  (start_pb),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .wr_drop   (wr_drop)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  idx;
    logic        lst;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_mem [8];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;

  // Monitor bookkeeping
  bit          first_pending = 0;
  int unsigned pin_cyc = 0;
  int unsigned last_xfer_cyc = 0;
  bit          chk_done = 0;
  logic        prev_valid = 0;
  logic        prev_ready = 0;
  logic [15:0] prev_data = '0;
  logic [2:0]  prev_idx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    model_mem[0] = 16'h0000; model_mem[1] = 16'h8800;
    model_mem[2] = 16'h0100; model_mem[3] = 16'h8000;
    model_mem[4] = 16'h0001; model_mem[5] = 16'h0800;
    model_mem[6] = 16'h8110; model_mem[7] = 16'h0080;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pacing, stall stability, scoreboard pops, done after last row.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      prev_ready = 0;
      chk_done   = 0;
    end else begin
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (chk_done) begin
        check("done_after_last", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        chk_done = 0;
      end
      if (prev_valid && prev_ready)
        check("valid_drops_after_xfer", {31'd0, row_valid}, 32'd0);
      if (row_valid && !prev_valid) begin
        if (first_pending) begin
          check("first_valid_latency", cyc, pin_cyc + PACE + 4);
          first_pending = 0;
        end else begin
          check("row_gap", cyc, last_xfer_cyc + PACE);
        end
      end
      if (row_valid && prev_valid && !prev_ready) begin
        check("stall_data", {16'd0, row_data}, {16'd0, prev_data});
        check("stall_idx", {29'd0, row_idx}, {29'd0, prev_idx});
      end
      if (row_valid && row_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_row: got idx %0d data 0x%0h, expected none", row_idx, row_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("row_data", {16'd0, row_data}, {16'd0, e.data});
          check("row_idx", {29'd0, row_idx}, {29'd0, e.idx});
          check("row_last", {31'd0, last}, {31'd0, e.lst});
        end
        last_xfer_cyc = cyc + 1;
        if (row_idx == 3'd7) chk_done = 1;
      end
      prev_valid = row_valid;
      prev_ready = row_ready;
      prev_data  = row_data;
      prev_idx   = row_idx;
    end
  end

  task automatic write_row(input logic [2:0] a, input logic [15:0] d, input bit expect_drop);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    #1;
    check("wr_drop", {31'd0, wr_drop}, {31'd0, expect_drop});
    tick();
    wr_en = 1'b0;
    if (!expect_drop) model_mem[a] = d;
  endtask

  task automatic press_start(input bit expect_run);
    start_pb = 1'b1;
    if (expect_run) begin
      pin_cyc = cyc;
      first_pending = 1;
      for (int i = 0; i < 8; i++) begin
        exp_t e;
        e.data = model_mem[i];
        e.idx  = 3'(i);
        e.lst  = (i == 7);
        exp_q.push_back(e);
      end
    end
    repeat (4) tick();
    start_pb = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_row(input logic [2:0] idx, input int unsigned budget);
    int unsigned n = 0;
    while (!(row_valid && row_idx == idx) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_row_timeout: row %0d not presented within %0d cycles", idx, budget);
    end
  endtask

  task automatic wait_done(input int unsigned budget, input bit rand_ready);
    int unsigned n = 0;
    while (!(done && exp_q.size() == 0) && n < budget) begin
      if (rand_ready) row_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    row_ready = 1'b1;
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done_timeout: done=%0d pending=%0d, expected done=1 pending=0", done, exp_q.size());
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start_pb = 1'b0; row_ready = 1'b1;
    model_reset();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_row_valid", {31'd0, row_valid}, 32'd0);
    check("rst_row_data", {16'd0, row_data}, 32'd0);
    check("rst_row_idx", {29'd0, row_idx}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);

    // 1: default image, ready always high
    press_start(1);
    wait_done(400, 0);

    // 2: backpressure on row 2 for 10 cycles
    press_start(1);
    wait_row(3'd1, 100);
    tick();
    row_ready = 1'b0;
    wait_row(3'd2, 100);
    check("stall_row2_data", {16'd0, row_data}, 32'h0100);
    repeat (10) tick();
    row_ready = 1'b1;
    wait_done(400, 0);

    // 3: accepted write in DONE, rejected write while busy
    write_row(3'd5, 16'h0004, 0);
    press_start(1);
    check("busy_in_wait", {31'd0, busy}, 32'd1);
    write_row(3'd1, 16'hFFFF, 1);
    wait_done(400, 0);

    // 4: start while presenting is ignored; start from DONE restarts at row 0
    press_start(1);
    wait_row(3'd3, 100);
    row_ready = 1'b0;
    press_start(0);
    row_ready = 1'b1;
    wait_done(400, 0);
    press_start(1);
    wait_done(400, 0);

    // 5: reset while row 4 is presented, written row 5 reverts
    write_row(3'd5, 16'h1234, 0);
    press_start(1);
    wait_row(3'd4, 100);
    rst = 1'b1;
    tick();
    check("midrst_row_valid", {31'd0, row_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    tick();
    press_start(1);
    wait_done(400, 0);

    // Randomized runs: random writes between runs, random downstream ready
    for (int r = 0; r < 4; r++) begin
      int unsigned nw;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < int'(nw); w++)
        write_row(3'($urandom_range(0, 7)), 16'($urandom), 0);
      press_start(1);
      wait_done(800, 1);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
